// File: rtl/accum_adder_if.sv
// Handshake bundle for accum_adder: operand beats in, burst results out.
// The master side drives operands and out_ready; the slave side is the adder.
interface accum_adder_if #(
    parameter int WIDTH   = 4,
    parameter int ACC_W   = 8,
    parameter int COUNT_W = 8
);
    logic [WIDTH-1:0]   s1;
    logic [WIDTH-1:0]   s2;
    logic               mode;
    logic               in_last;
    logic               in_valid;
    logic               in_ready;
    logic [ACC_W-1:0]   sum;
    logic               overflow;
    logic [COUNT_W-1:0] count;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output s1, s2, mode, in_last, in_valid, out_ready,
        input  in_ready, sum, overflow, count, out_valid
    );

    modport slave (
        input  s1, s2, mode, in_last, in_valid, out_ready,
        output in_ready, sum, overflow, count, out_valid
    );
endinterface

// File: rtl/accum_adder.sv
// Pairwise / burst-accumulating adder with valid-ready on both sides.
// Define ACCUM_SAT_EN to clamp the accumulator at all-ones instead of wrapping.
module accum_adder #(
    parameter int WIDTH   = 4,
    parameter int ACC_W   = 8,
    parameter int COUNT_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    accum_adder_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic               overflow_q, overflow_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               out_valid_q, out_valid_d;

    logic               beat_accept;
    logic               result_take;
    logic [ACC_W-1:0]   pair_sum;
    logic [ACC_W:0]     ext_sum;
    logic [ACC_W-1:0]   acc_upd;
    logic [COUNT_W-1:0] cnt_upd;
    logic               ovf_upd;

    // A pending result blocks input unless it is being taken in the same cycle.
    assign bus.in_ready = !reset && (!out_valid_q || bus.out_ready);
    assign beat_accept  = bus.in_valid && bus.in_ready;
    assign result_take  = out_valid_q && bus.out_ready;

    // ACC_W >= WIDTH+1, so one extra bit holds the full carry of acc+s1+s2.
    assign pair_sum = ACC_W'(bus.s1) + ACC_W'(bus.s2);
    assign ext_sum  = {1'b0, acc_q} + (ACC_W+1)'(bus.s1) + (ACC_W+1)'(bus.s2);
    assign ovf_upd  = ovf_q | ext_sum[ACC_W];
    assign cnt_upd  = (cnt_q == '1) ? cnt_q : cnt_q + COUNT_W'(1);

`ifdef ACCUM_SAT_EN
    // Once any carry has occurred in this burst the accumulator stays pinned.
    assign acc_upd = ovf_upd ? '1 : ext_sum[ACC_W-1:0];
`else
    assign acc_upd = ext_sum[ACC_W-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        sum_d       = sum_q;
        overflow_d  = overflow_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;

        if (result_take) begin
            out_valid_d = 1'b0;
        end

        if (beat_accept) begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.mode) begin
                        sum_d       = pair_sum;
                        overflow_d  = 1'b0;
                        count_d     = COUNT_W'(1);
                        out_valid_d = 1'b1;
                    end else begin
                        acc_d = pair_sum;
                        cnt_d = COUNT_W'(1);
                        ovf_d = 1'b0;
                        if (bus.in_last) begin
                            sum_d       = pair_sum;
                            overflow_d  = 1'b0;
                            count_d     = COUNT_W'(1);
                            out_valid_d = 1'b1;
                        end else begin
                            state_d = ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    // mode is not consulted here: a burst only ends on in_last.
                    acc_d = acc_upd;
                    cnt_d = cnt_upd;
                    ovf_d = ovf_upd;
                    if (bus.in_last) begin
                        sum_d       = acc_upd;
                        overflow_d  = ovf_upd;
                        count_d     = cnt_upd;
                        out_valid_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            sum_q       <= '0;
            overflow_q  <= 1'b0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            sum_q       <= sum_d;
            overflow_q  <= overflow_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.overflow  = overflow_q;
    assign bus.count     = count_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_accum_adder.sv
// Directed vector table, hand-written burst corners and random traffic for accum_adder,
// all checked against a burst-total reference model.
module tb_accum_adder;
    localparam int WIDTH   = 4;
    localparam int ACC_W   = 8;
    localparam int COUNT_W = 8;
    localparam int ACC_MOD = 1 << ACC_W;
    localparam int CNT_MAX = (1 << COUNT_W) - 1;
`ifdef ACCUM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic reset;

    accum_adder_if #(.WIDTH(WIDTH), .ACC_W(ACC_W), .COUNT_W(COUNT_W)) bus ();

    accum_adder #(.WIDTH(WIDTH), .ACC_W(ACC_W), .COUNT_W(COUNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_fail;

    // Reference model: a burst is just a running integer total and beat count.
    bit mdl_valid;
    int mdl_sum;
    bit mdl_ovf;
    int mdl_cnt;
    bit in_burst;
    int burst_total;
    int burst_n;

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             m;
        logic             l;
        logic             ordy;
        logic             ev;
        logic [ACC_W-1:0] es;
        logic             eo;
        logic [COUNT_W-1:0] ec;
    } vec_t;

    vec_t tbl [0:15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_emit();
        mdl_valid = 1'b1;
        mdl_cnt   = (burst_n > CNT_MAX) ? CNT_MAX : burst_n;
        mdl_ovf   = (burst_total >= ACC_MOD);
        if (mdl_ovf && SAT) mdl_sum = ACC_MOD - 1;
        else                mdl_sum = burst_total % ACC_MOD;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(mdl_valid));
        chk({tag, ".sum"},       32'(bus.sum),       32'(mdl_sum));
        chk({tag, ".overflow"},  32'(bus.overflow),  32'(mdl_ovf));
        chk({tag, ".count"},     32'(bus.count),     32'(mdl_cnt));
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs checked.
    task automatic step(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic m, input logic l, input logic ordy);
        bit exp_rdy;
        bit accepted;
        bus.in_valid  = v;
        bus.s1        = a;
        bus.s2        = b;
        bus.mode      = m;
        bus.in_last   = l;
        bus.out_ready = ordy;
        #1;
        n_vec++;
        exp_rdy = !mdl_valid || ordy;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        accepted = v && exp_rdy;
        if (mdl_valid && ordy) mdl_valid = 1'b0;
        if (accepted) begin
            if (!in_burst) begin
                burst_total = int'(a) + int'(b);
                burst_n     = 1;
                if (!m || l) model_emit();
                else         in_burst = 1'b1;
            end else begin
                burst_total += int'(a) + int'(b);
                burst_n++;
                if (l) begin
                    model_emit();
                    in_burst = 1'b0;
                end
            end
        end
        @(negedge clk);
        check_outputs("step");
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        n_vec++;
        chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        mdl_valid   = 1'b0;
        mdl_sum     = 0;
        mdl_ovf     = 1'b0;
        mdl_cnt     = 0;
        in_burst    = 1'b0;
        burst_total = 0;
        burst_n     = 0;
        check_outputs("rst");
        reset        = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        reset  = 1'b1;
        bus.s1 = '0;
        bus.s2 = '0;
        bus.mode = 1'b0;
        bus.in_last = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;

        //             v     a     b     m     l     ordy  ev    sum    ovf   cnt
        tbl[0]  = '{1'b1, 4'hF, 4'h1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 8'd1};
        tbl[1]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 1'b0, 8'd1};
        tbl[2]  = '{1'b1, 4'h3, 4'h4, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 1'b0, 8'd1};
        tbl[3]  = '{1'b1, 4'h5, 4'h6, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 1'b0, 8'd1};
        tbl[4]  = '{1'b1, 4'h1, 4'h1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h14, 1'b0, 8'd3};
        for (int i = 5; i < 10; i++)
            tbl[i] = '{1'b1, 4'h7, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1, 8'h14, 1'b0, 8'd3};
        tbl[10] = '{1'b1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 1'b0, 8'd1};
        tbl[11] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 1'b0, 8'd1};
        tbl[12] = '{1'b1, 4'h1, 4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 1'b0, 8'd1};
        tbl[13] = '{1'b1, 4'h3, 4'h4, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 1'b0, 8'd1};
        tbl[14] = '{1'b1, 4'h5, 4'h6, 1'b0, 1'b1, 1'b1, 1'b1, 8'h15, 1'b0, 8'd3};
        tbl[15] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h15, 1'b0, 8'd3};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].l, tbl[i].ordy);
            chk($sformatf("tbl%0d.out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d.sum", i),       32'(bus.sum),       32'(tbl[i].es));
            chk($sformatf("tbl%0d.overflow", i),  32'(bus.overflow),  32'(tbl[i].eo));
            chk($sformatf("tbl%0d.count", i),     32'(bus.count),     32'(tbl[i].ec));
        end

        // 20 beats of (F,F): total 600 wraps to 0x58, or clamps to 0xFF.
        for (int i = 0; i < 20; i++) step(1'b1, 4'hF, 4'hF, 1'b1, (i == 19), 1'b1);
        chk("sat20.sum", 32'(bus.sum), SAT ? 32'hFF : 32'h58);
        chk("sat20.overflow", 32'(bus.overflow), 32'd1);
        chk("sat20.count", 32'(bus.count), 32'd20);
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);

        // Reset mid-burst discards the partial total.
        step(1'b1, 4'h9, 4'h9, 1'b1, 1'b0, 1'b1);
        step(1'b1, 4'h9, 4'h9, 1'b1, 1'b0, 1'b1);
        do_reset();
        chk("midrst.out_valid", 32'(bus.out_valid), 32'd0);
        step(1'b1, 4'h2, 4'h2, 1'b1, 1'b1, 1'b1);
        chk("midrst.sum", 32'(bus.sum), 32'd4);
        chk("midrst.count", 32'(bus.count), 32'd1);
        chk("midrst.out_valid2", 32'(bus.out_valid), 32'd1);
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);

        // 300 beats of (0,1): count saturates at 255, total 300 carries once.
        for (int i = 0; i < 300; i++) step(1'b1, 4'h0, 4'h1, 1'b1, (i == 299), 1'b1);
        chk("cnt300.count", 32'(bus.count), 32'd255);
        chk("cnt300.sum", 32'(bus.sum), SAT ? 32'hFF : 32'd44);
        chk("cnt300.overflow", 32'(bus.overflow), 32'd1);

        // Random traffic, including idle gaps, back-pressure and mid-burst mode changes.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0),
                 WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) < 7));
            if (i == 1500) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
